// File: rtl/adder_4bit.sv
// Registered 4-bit ripple-carry adder with one-cycle latency and asynchronous active-high reset.
// Optional signed-overflow output is enabled by defining ADDER_4BIT_OVERFLOW_EN.
module adder_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       carry
`ifdef ADDER_4BIT_OVERFLOW_EN
    ,
    output logic       overflow
`endif
);

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

    logic [3:0] sum_s;
    logic [4:0] c_s;
    logic [3:0] sum_r;
    logic       carry_r;

    // Ripple the carry through the four full-adder stages, c[0] fed by Cin.
    always_comb begin
        logic [4:0] c_v;
        logic [1:0] fa_v;
        c_v    = 5'b00000;
        sum_s  = 4'b0000;
        fa_v   = 2'b00;
        c_v[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            fa_v       = full_add(A[i], B[i], c_v[i]);
            sum_s[i]   = fa_v[0];
            c_v[i+1]   = fa_v[1];
        end
        c_s = c_v;
    end

    // Output registers; reset forces zero immediately and discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r   <= 4'b0000;
            carry_r <= 1'b0;
        end else begin
            sum_r   <= sum_s;
            carry_r <= c_s[4];
        end
    end

    assign sum   = sum_r;
    assign carry = carry_r;

`ifdef ADDER_4BIT_OVERFLOW_EN
    logic overflow_r;

    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= c_s[4] ^ c_s[3];
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: reset, directed vectors, mid-cycle holds and full sweep.
`timescale 1ns/1ps
module tb_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] sum;
    logic       carry;
`ifdef ADDER_4BIT_OVERFLOW_EN
    logic       overflow;
`endif

    int checks;
    int errors;

    adder_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .sum      (sum),
        .carry    (carry)
`ifdef ADDER_4BIT_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        // Reset asserted from time 0 with non-zero operands present.
        #2;
        checks++;
        if ({carry, sum} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async: got %b required 00000", {carry, sum});
        end
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold_edge: got %b required 00000", {carry, sum});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({carry, sum} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release_no_edge: got %b required 00000", {carry, sum});
        end
        // First edge after release captures 1111+1111+1.
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_first_edge: got %b required 11111", {carry, sum});
        end
`ifdef ADDER_4BIT_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge_ovf: got %b required 0", overflow);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [3:0] a_t [5];
        logic [3:0] b_t [5];
        logic [4:0] e_t [5];
        a_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1101};
        b_t = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
        e_t = '{5'b00010, 5'b00100, 5'b00111, 5'b01101, 5'b10010};
        Cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = a_t[i];
            B = b_t[i];
            @(posedge clk); #1;
            checks++;
            if ({carry, sum} !== e_t[i]) begin
                errors++;
                $display("FAIL seq[%0d]: got %b required %b", i, {carry, sum}, e_t[i]);
            end
`ifdef ADDER_4BIT_OVERFLOW_EN
            checks++;
            if (overflow !== 1'b0) begin
                errors++;
                $display("FAIL seq_ovf[%0d]: got %b required 0", i, overflow);
            end
`endif
        end
    endtask

    task automatic test_boundaries;
        logic [3:0] a_t [5];
        logic [3:0] b_t [5];
        logic       c_t [5];
        logic [4:0] e_t [5];
        logic       o_t [5];
        a_t = '{4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b0000};
        b_t = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
        c_t = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
        e_t = '{5'b10000, 5'b01000, 5'b10000, 5'b11111, 5'b00000};
        o_t = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0};
        for (int i = 0; i < 5; i++) begin
            A   = a_t[i];
            B   = b_t[i];
            Cin = c_t[i];
            @(posedge clk); #1;
            checks++;
            if ({carry, sum} !== e_t[i]) begin
                errors++;
                $display("FAIL boundary[%0d]: got %b required %b", i, {carry, sum}, e_t[i]);
            end
`ifdef ADDER_4BIT_OVERFLOW_EN
            checks++;
            if (overflow !== o_t[i]) begin
                errors++;
                $display("FAIL boundary_ovf[%0d]: got %b required %b", i, overflow, o_t[i]);
            end
`endif
        end
    endtask

    task automatic test_reset_mid;
        A = 4'b1001; B = 4'b0100; Cin = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b01101) begin
            errors++;
            $display("FAIL pre_reset: got %b required 01101", {carry, sum});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({carry, sum} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_async: got %b required 00000", {carry, sum});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({carry, sum} !== 5'b00000) begin
                errors++;
                $display("FAIL mid_reset_hold[%0d]: got %b required 00000", i, {carry, sum});
            end
        end
        // 0011+0100+1 = 01000, signed 3+4+1 overflows.
        A = 4'b0011; B = 4'b0100; Cin = 1'b1;
        #2 rst = 1'b0;
        #2;
        checks++;
        if ({carry, sum} !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_release: got %b required 00000", {carry, sum});
        end
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_reset_first_edge: got %b required 01000", {carry, sum});
        end
`ifdef ADDER_4BIT_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_first_ovf: got %b required 1", overflow);
        end
`endif
    endtask

    task automatic test_hold;
        A = 4'b0101; B = 4'b0110; Cin = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b01011) begin
            errors++;
            $display("FAIL hold_load: got %b required 01011", {carry, sum});
        end
        #2 A = 4'b1111; B = 4'b1110; Cin = 1'b1;
        #3;
        checks++;
        if ({carry, sum} !== 5'b01011) begin
            errors++;
            $display("FAIL hold_midcycle: got %b required 01011", {carry, sum});
        end
        @(posedge clk); #1;
        checks++;
        if ({carry, sum} !== 5'b11110) begin
            errors++;
            $display("FAIL hold_next_edge: got %b required 11110", {carry, sum});
        end
    endtask

    task automatic test_sweep;
        logic [4:0] exp_v;
        logic       ovf_v;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    A   = 4'(a);
                    B   = 4'(b);
                    Cin = 1'(c);
                    exp_v = 5'(a + b + c);
                    ovf_v = (A[3] == B[3]) && (exp_v[3] != A[3]);
                    @(posedge clk); #1;
                    checks++;
                    if ({carry, sum} !== exp_v) begin
                        errors++;
                        $display("FAIL sweep %0d+%0d+%0d: got %b required %b", a, b, c, {carry, sum}, exp_v);
                    end
`ifdef ADDER_4BIT_OVERFLOW_EN
                    checks++;
                    if (overflow !== ovf_v) begin
                        errors++;
                        $display("FAIL sweep_ovf %0d+%0d+%0d: got %b required %b", a, b, c, overflow, ovf_v);
                    end
`else
                    if (ovf_v === 1'bx) begin
                        $display("sweep overflow model undefined");
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        A   = 4'b1111;
        B   = 4'b1111;
        Cin = 1'b1;
        test_reset();
        test_back_to_back();
        test_boundaries();
        test_reset_mid();
        test_hold();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
